// File: rtl/uart_sample_framer.sv
// uart_sample_framer: snapshots N_CH signed samples on a decimated sample_clk
// rising edge and streams them as a byte frame:
//   A5 5A SEQ DATA[N_CH*NB] CSUM
// The checksum is the XOR of SEQ and the DATA bytes. A snapshot request that
// arrives while a frame is still in flight is dropped and counted.
module uart_sample_framer #(
    parameter int N_CH     = 4,
    parameter int W        = 16,
    parameter int DECIMATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_clk,
    input  logic [N_CH*W-1:0] samples_in,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [7:0]        overrun_count
);

    localparam int NB     = (W + 7) / 8;
    localparam int NBYTES = N_CH * NB;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [15:0]      DLAST    = 16'(DECIMATE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SEQ, DATA, CSUM} state_t;

    state_t                  state_q, state_d;
    logic                    sclk_q, sclk_d;
    logic [15:0]             dcnt_q, dcnt_d;
    logic [7:0]              seq_q, seq_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [7:0]              ovr_q, ovr_d;
    logic [NBYTES-1:0][7:0]  snap_q, snap_d;

    // Snapshot bytes in transmit order: byte 0 is the MSB byte of channel 0.
    logic [NBYTES-1:0][7:0]  snap_in;

    // Sign-extend each channel to NB*8 bits and split it into bytes, MSB byte first.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [NB*8-1:0] ext;
        for (genvar i = 0; i < NB*8; i++) begin : g_bit
            if (i < W) begin : g_in
                assign ext[i] = samples_in[c*W + i];
            end else begin : g_sx
                assign ext[i] = samples_in[c*W + W - 1];
            end
        end
        for (genvar b = 0; b < NB; b++) begin : g_byte
            assign snap_in[c*NB + b] = ext[(NB-1-b)*8 +: 8];
        end
    end

    logic       sclk_rise, eligible, xfer;
    logic [7:0] data_byte;

    // Edge detect, decimation, frame FSM and the overrun counter.
    always_comb begin
        sclk_d    = sample_clk;
        dcnt_d    = dcnt_q;
        state_d   = state_q;
        seq_d     = seq_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        ovr_d     = ovr_q;
        snap_d    = snap_q;
        data_byte = 8'h00;

        sclk_rise = sample_clk & ~sclk_q;
        eligible  = sclk_rise && (dcnt_q == 16'd0);
        xfer      = (state_q != IDLE) && tx_ready;

        if (sclk_rise) dcnt_d = (dcnt_q == DLAST) ? 16'd0 : dcnt_q + 16'd1;

        for (int i = 0; i < NBYTES; i++)
            if (idx_q == IDX_W'(i)) data_byte = snap_q[i];

        case (state_q)
            IDLE: if (eligible) begin
                snap_d  = snap_in;
                state_d = SYNC0;
            end
            SYNC0: if (xfer) state_d = SYNC1;
            SYNC1: if (xfer) state_d = SEQ;
            SEQ: if (xfer) begin
                csum_d  = seq_q;
                state_d = DATA;
            end
            DATA: if (xfer) begin
                csum_d = csum_q ^ data_byte;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = CSUM;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            CSUM: if (xfer) begin
                seq_d   = seq_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Any eligible edge outside IDLE, including the CSUM transfer cycle, is dropped.
        if (eligible && (state_q != IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    end

    // Output byte is a pure function of registered state, so it holds under stall.
    always_comb begin
        tx_valid      = (state_q != IDLE);
        busy          = (state_q != IDLE);
        overrun_count = ovr_q;
        case (state_q)
            SYNC0:   tx_data = 8'hA5;
            SYNC1:   tx_data = 8'h5A;
            SEQ:     tx_data = seq_q;
            DATA:    tx_data = data_byte;
            CSUM:    tx_data = csum_q;
            default: tx_data = 8'h00;
        endcase
    end

    // State registers; sample_clk copy resets high so a held-high strobe is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sclk_q  <= 1'b1;
            dcnt_q  <= '0;
            seq_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            ovr_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            dcnt_q  <= dcnt_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
        end
    end

endmodule

// File: tb/tb_uart_sample_framer.sv
// Directed bench for uart_sample_framer: instance A (2x16-bit, no decimation)
// and instance B (1x12-bit, decimate by 4), with hand-computed byte streams.
module tb_uart_sample_framer;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_sclk, a_ready, a_valid, a_busy;
    logic [31:0] a_samples;
    logic [7:0]  a_data, a_ovr;

    logic        b_sclk, b_ready, b_valid, b_busy;
    logic [11:0] b_samples;
    logic [7:0]  b_data, b_ovr;

    int checks = 0;
    int errors = 0;

    logic [7:0] aq[$];
    logic [7:0] bq[$];

    uart_sample_framer #(.N_CH(2), .W(16), .DECIMATE(1)) u_a (
        .clk(clk), .rst(rst), .sample_clk(a_sclk), .samples_in(a_samples),
        .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
        .busy(a_busy), .overrun_count(a_ovr)
    );

    uart_sample_framer #(.N_CH(1), .W(12), .DECIMATE(4)) u_b (
        .clk(clk), .rst(rst), .sample_clk(b_sclk), .samples_in(b_samples),
        .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
        .busy(b_busy), .overrun_count(b_ovr)
    );

    always #5 clk = ~clk;

    // Byte monitors: a byte offered with ready high transfers at the next rising edge.
    always @(negedge clk) if (a_valid && a_ready) aq.push_back(a_data);
    always @(negedge clk) if (b_valid && b_ready) bq.push_back(b_data);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic a_start(input logic [31:0] s);
        a_samples = s;
        a_sclk    = 1'b1;
        step();
        a_sclk    = 1'b0;
    endtask

    task automatic b_pulse(input logic [11:0] s);
        b_samples = s;
        b_sclk    = 1'b1;
        step();
        b_sclk    = 1'b0;
        repeat (9) step();
    endtask

    task automatic a_wait_idle(input string tag);
        int n = 0;
        while (a_busy && n < 200) begin step(); n++; end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic a_wait_q(input string tag, input int sz);
        int n = 0;
        while (aq.size() < sz && n < 200) begin step(); n++; end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    logic [7:0] e029 [8]  = '{8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    logic [7:0] e032 [8]  = '{8'hA5, 8'h5A, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [7:0] eb   [12] = '{8'hA5, 8'h5A, 8'h00, 8'hF8, 8'h00, 8'hF8,
                              8'hA5, 8'h5A, 8'h01, 8'h07, 8'hFF, 8'hF9};

    initial begin
        int bad;
        rst = 1'b1; a_sclk = 1'b1; b_sclk = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        a_samples = 32'h0; b_samples = 12'h0;
        repeat (3) step();
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_data",  32'(a_data),  32'd0);
        chk("rst_a_busy",  32'(a_busy),  32'd0);
        chk("rst_a_ovr",   32'(a_ovr),   32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);

        // Strobe held high across reset release must not start a frame.
        rst = 1'b0;
        repeat (3) step();
        chk("held_hi_a_busy", 32'(a_busy), 32'd0);
        chk("held_hi_b_busy", 32'(b_busy), 32'd0);
        a_sclk = 1'b0; b_sclk = 1'b0;
        repeat (2) step();

        // Instance B: 8 edges, decimate by 4 -> two frames (0x800, then 0x7FF).
        b_pulse(12'h800);
        b_pulse(12'h123);
        b_pulse(12'h456);
        b_pulse(12'h789);
        b_pulse(12'h7FF);
        b_pulse(12'h111);
        b_pulse(12'h222);
        b_pulse(12'h333);
        chk("b_nbytes", 32'(bq.size()), 32'd12);
        for (int i = 0; i < 12; i++) chk($sformatf("b_byte%0d", i), 32'(bq[i]), 32'(eb[i]));
        chk("b_ovr",  32'(b_ovr),  32'd0);
        chk("b_busy", 32'(b_busy), 32'd0);

        // Instance A: first frame, ch0=0x1234 ch1=0xABCD.
        aq.delete();
        a_start(32'hABCD_1234);
        a_wait_idle("a029_idle");
        chk("a029_nbytes", 32'(aq.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("a029_byte%0d", i), 32'(aq[i]), 32'(e029[i]));
        chk("a029_valid_low", 32'(a_valid), 32'd0);

        // Stall during DATA with an extra eligible edge and changed inputs.
        aq.delete();
        a_start(32'h0304_0102);
        a_wait_q("a032_wait4", 4);
        a_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin a_samples = 32'hDEAD_BEEF; a_sclk = 1'b1; end
            if (i == 6) a_sclk = 1'b0;
            step();
            if (a_data !== 8'h02 || a_valid !== 1'b1) bad++;
        end
        chk("a032_stall_stable", 32'(bad), 32'd0);
        a_ready = 1'b1;
        a_wait_idle("a032_idle");
        chk("a032_nbytes", 32'(aq.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("a032_byte%0d", i), 32'(aq[i]), 32'(e032[i]));
        chk("a032_ovr", 32'(a_ovr), 32'd1);

        // 300 eligible edges during a stalled frame saturate the counter.
        a_ready = 1'b0;
        a_start(32'h0000_0000);
        repeat (300) begin
            a_sclk = 1'b1; step();
            a_sclk = 1'b0; step();
        end
        chk("a033_ovr_sat", 32'(a_ovr), 32'd255);
        a_ready = 1'b1;
        a_wait_idle("a033_idle");

        // Reset after the SEQ byte aborts the frame.
        aq.delete();
        a_start(32'h5555_AAAA);
        a_wait_q("a034_wait3", 3);
        chk("a034_seq3", 32'(aq[2]), 32'h03);
        rst = 1'b1;
        step();
        chk("a034_valid_after_rst", 32'(a_valid), 32'd0);
        chk("a034_busy_after_rst",  32'(a_busy),  32'd0);
        rst = 1'b0;
        aq.delete();
        repeat (5) step();
        chk("a034_no_partial", 32'(aq.size()), 32'd0);
        chk("a034_ovr_cleared", 32'(a_ovr), 32'd0);
        a_start(32'h0000_0001);
        a_wait_idle("a034_idle");
        chk("a034_b0", 32'(aq[0]), 32'hA5);
        chk("a034_b1", 32'(aq[1]), 32'h5A);
        chk("a034_b2", 32'(aq[2]), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_sample_framer.md
UART_SAMPLE_FRAMER -- requirements
Module: uart_sample_framer

Interface
REQ-001 Parameter N_CH, default 4: number of sample channels per frame, legal range 1..8.
REQ-002 Parameter W, default 16: bits per sample, legal range 8..32; NB = ceil(W/8) bytes per sample.
REQ-003 Parameter DECIMATE, default 1: one frame per DECIMATE sample_clk rising edges, legal range 1..65535.
REQ-004 clk  in  1  system clock; all logic is on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 sample_clk  in  1  codec sample strobe, level signal synchronous to clk; a frame event is its rising edge.
REQ-007 samples_in  in  N_CH*W  signed samples; channel c occupies bits [c*W+W-1 : c*W].
REQ-008 tx_data  out  8  byte offered to the UART transmitter.
REQ-009 tx_valid  out  1  tx_data holds a valid byte.
REQ-010 tx_ready  in  1  UART accepts the byte; transfer occurs on a cycle with tx_valid=1 and tx_ready=1.
REQ-011 busy  out  1  high while a frame is in progress (state != IDLE).
REQ-012 overrun_count  out  8  saturating count of dropped snapshots.

Function
REQ-013 Edge detect SHALL use a registered copy sample_clk_q; edge = sample_clk & ~sample_clk_q.
REQ-014 Decimation counter dcnt, 16 bits, range 0..DECIMATE-1, SHALL advance on every edge and wrap to 0 after DECIMATE-1; an edge with dcnt==0 is eligible.
REQ-015 Eligible edge in IDLE: samples_in SHALL be latched into the snapshot register on that clk edge, and FSM enters SYNC0 with tx_valid=1 on the following cycle.
REQ-016 Eligible edge while not IDLE: snapshot SHALL NOT change, the current frame SHALL continue, and overrun_count SHALL increment, saturating at 255.
REQ-017 FSM states: IDLE, SYNC0, SYNC1, SEQ, DATA, CSUM; each non-IDLE state advances only on a transfer.
REQ-018 Bytes: SYNC0=0xA5, SYNC1=0x5A, SEQ=8-bit frame sequence number, DATA=N_CH*NB sample bytes, CSUM=checksum byte.
REQ-019 DATA order: channel 0 first; within a channel, MSB byte first; each sample is sign-extended from W to NB*8 bits.
REQ-020 DATA SHALL use a byte index 0..N_CH*NB-1; transfer of the last index moves to CSUM.
REQ-021 Checksum: XOR of the SEQ byte and all DATA bytes. Sync bytes are excluded.
REQ-022 A transfer in CSUM SHALL increment the sequence number (wrap 255->0) and return to IDLE with tx_valid=0 on the next cycle.
REQ-023 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable; tx_valid SHALL NOT deassert until a transfer occurs.
REQ-024 An eligible edge on the same cycle as the CSUM transfer counts as an overrun (REQ-016); no back-to-back frame starts.
REQ-025 tx_valid SHALL be low in IDLE; there are no gaps between bytes of a frame other than those caused by tx_ready=0.

Reset
REQ-026 On rst: FSM=IDLE, tx_valid=0, tx_data=0, busy=0, overrun_count=0, sequence=0, dcnt=0, byte index=0, checksum=0, snapshot=0.
REQ-027 sample_clk_q SHALL reset to 1, so a sample_clk held high through reset release produces no edge.
REQ-028 rst asserted mid-frame SHALL abort the frame; tx_valid=0 on the cycle after rst is sampled, and no partial frame bytes follow.

Verification
REQ-029 N_CH=2, W=16, tx_ready=1, samples 0x1234, 0xABCD, first frame -> bytes A5 5A 00 12 34 AB CD 40; busy falls after 0x40.
REQ-030 W=12, N_CH=1, sample 0x800 -> DATA bytes F8 00, checksum F8 (seq 0); sample 0x7FF -> 07 FF.
REQ-031 DECIMATE=4, 8 edges spaced wider than one frame -> exactly 2 frames with SEQ 00 then 01; overrun_count stays 0.
REQ-032 tx_ready=0 for 20 cycles during DATA, plus a second eligible edge in that window -> tx_data stable throughout, frame completes unchanged with the original snapshot, overrun_count=1.
REQ-033 300 eligible edges during a stalled frame -> overrun_count saturates at 255.
REQ-034 rst pulse after the SEQ byte -> tx_valid=0 next cycle; the next frame starts with A5 5A 00.
